// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_TIMEOUT  = 16;
  localparam int DEF_FAIR_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  function automatic logic is_busy(input arb_state_e s);
    return (s == BUSY_I) || (s == BUSY_D);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable, saturating cycle counter that flags the increment reaching TIMEOUT.
module mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT_C  = CW'(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise count up until saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != SAT_C)) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High only on the cycle whose increment would take the count to TIMEOUT.
  assign expired = inc && (count_q == LAST_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single valid/ready memory port with
// data priority, instruction starvation guard and response timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int FAIR_MAX = DEF_FAIR_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_valid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          bus_err
);

  localparam int FW = $clog2(FAIR_MAX + 1);
  localparam logic [FW-1:0] FAIR_MAX_C = FW'(FAIR_MAX);

  arb_state_e    state_q,   state_d;
  logic          m_valid_q, m_valid_d;
  logic          m_we_q,    m_we_d;
  logic [AW-1:0] m_addr_q,  m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;
  logic          bus_err_q, bus_err_d;
  logic [FW-1:0] fair_q,    fair_d;

  logic grant_s;
  logic is_instr_s;
  logic tmr_inc_s;
  logic tmr_expired_s;
  logic instr_turn_s;

  assign is_instr_s   = (state_q == BUSY_I);
  assign tmr_inc_s    = is_busy(state_q) && !m_ready;
  assign instr_turn_s = i_req && (fair_q == FAIR_MAX_C);

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant_s),
    .inc    (tmr_inc_s),
    .expired(tmr_expired_s)
  );

  // Arbitration, transaction sequencing and response capture.
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    bus_err_d = 1'b0;
    fair_d    = fair_q;
    grant_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && !instr_turn_s) begin
          grant_s   = 1'b1;
          state_d   = BUSY_D;
          m_valid_d = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          // Only grants that make the fetch port wait count toward fairness.
          if (i_req && (fair_q != FAIR_MAX_C)) begin
            fair_d = fair_q + FW'(1);
          end else begin
            fair_d = fair_q;
          end
        end else if (i_req) begin
          grant_s   = 1'b1;
          state_d   = BUSY_I;
          m_valid_d = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          fair_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          state_d   = DONE;
          m_valid_d = 1'b0;
          i_ready_d = is_instr_s;
          d_ready_d = !is_instr_s;
          if (is_instr_s) begin
            i_rdata_d = m_rdata;
          end else if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else if (tmr_expired_s) begin
          state_d   = DONE;
          m_valid_d = 1'b0;
          i_ready_d = is_instr_s;
          d_ready_d = !is_instr_s;
          bus_err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      bus_err_q <= 1'b0;
      fair_q    <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      bus_err_q <= bus_err_d;
      fair_q    <= fair_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one task per scenario.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          m_valid;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(16), .FAIR_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (m_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    ok = (m_valid === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;
    tick(); tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b exp 0", m_valid); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rst_m_we got %0b exp 0", m_we); end
    checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b%0b exp 00", i_ready, d_ready); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %0b exp 0", bus_err); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_addr_wdata got %h %h exp 0 0", m_addr, m_wdata); end
    checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h %h exp 0 0", i_rdata, d_rdata); end
    checks++; if (dut.fair_q !== 3'd0) begin errors++; $display("FAIL rst_fair got %0d exp 0", dut.fair_q); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp IDLE", dut.state_q); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_instr_read();
    i_req = 1'b1; i_addr = 32'h0000_0100;
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ird_m_valid got %0b exp 1", m_valid); end
    checks++; if (m_addr !== 32'h0000_0100) begin errors++; $display("FAIL ird_m_addr got %h exp 00000100", m_addr); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL ird_m_we got %0b exp 0", m_we); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL ird_early_ready got %0b exp 0", i_ready); end
    m_ready = 1'b1; m_rdata = 32'h0050_0093;
    tick();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL ird_i_ready got %0b exp 1", i_ready); end
    checks++; if (i_rdata !== 32'h0050_0093) begin errors++; $display("FAIL ird_i_rdata got %h exp 00500093", i_rdata); end
    checks++; if (bus_err !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL ird_err_dready got %0b%0b exp 00", bus_err, d_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ird_valid_drop got %0b exp 0", m_valid); end
    i_req = 1'b0; m_ready = 1'b0;
    tick();
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL ird_pulse_len got %0b exp 0", i_ready); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ird_state got %0d exp IDLE", dut.state_q); end
  endtask

  task automatic test_priority();
    i_req = 1'b1; i_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (m_valid !== 1'b1 || m_we !== 1'b1) begin errors++; $display("FAIL pri_d_grant got v=%0b we=%0b exp 1 1", m_valid, m_we); end
    checks++; if (m_addr !== 32'h0000_2000) begin errors++; $display("FAIL pri_d_addr got %h exp 00002000", m_addr); end
    checks++; if (m_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pri_d_wdata got %h exp deadbeef", m_wdata); end
    checks++; if (dut.fair_q !== 3'd1) begin errors++; $display("FAIL pri_fair got %0d exp 1", dut.fair_q); end
    m_ready = 1'b1; m_rdata = 32'h7777_7777;
    tick();
    checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin errors++; $display("FAIL pri_d_ready got d=%0b i=%0b exp 1 0", d_ready, i_ready); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL pri_store_rdata got %h exp 0", d_rdata); end
    d_req = 1'b0; m_ready = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL pri_done_gap got v=%0b d=%0b exp 0 0", m_valid, d_ready); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h0000_0300) begin errors++; $display("FAIL pri_i_grant got v=%0b we=%0b a=%h exp 1 0 00000300", m_valid, m_we, m_addr); end
    m_ready = 1'b1; m_rdata = 32'h0000_0013;
    tick();
    checks++; if (i_ready !== 1'b1 || i_rdata !== 32'h0000_0013) begin errors++; $display("FAIL pri_i_done got r=%0b d=%h exp 1 00000013", i_ready, i_rdata); end
    i_req = 1'b0; m_ready = 1'b0;
    tick();
    checks++; if (dut.fair_q !== 3'd0) begin errors++; $display("FAIL pri_fair_clr got %0d exp 0", dut.fair_q); end
  endtask

  task automatic test_fairness();
    bit ok;
    i_req = 1'b1; i_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_wdata = '0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_wait got no m_valid exp grant %0d", k); i_req = 1'b0; d_req = 1'b0; return; end
      if (k < 4) begin
        checks++; if (m_addr !== 32'h0000_3000) begin errors++; $display("FAIL fair_data_grant got %h exp 00003000 (k=%0d)", m_addr, k); end
        checks++; if (dut.fair_q !== 3'(k + 1)) begin errors++; $display("FAIL fair_cnt got %0d exp %0d", dut.fair_q, k + 1); end
      end else begin
        checks++; if (m_addr !== 32'h0000_0400) begin errors++; $display("FAIL fair_instr_grant got %h exp 00000400", m_addr); end
        checks++; if (dut.fair_q !== 3'd0) begin errors++; $display("FAIL fair_cnt_clr got %0d exp 0", dut.fair_q); end
      end
      m_ready = 1'b1; m_rdata = 32'hA000_0000 + 32'(k);
      tick();
      if (k < 4) begin
        checks++; if (d_ready !== 1'b1 || d_rdata !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL fair_d_load got r=%0b d=%h exp 1 %h", d_ready, d_rdata, 32'hA000_0000 + 32'(k)); end
      end else begin
        checks++; if (i_ready !== 1'b1 || i_rdata !== 32'hA000_0004) begin errors++; $display("FAIL fair_i_done got r=%0b d=%h exp 1 a0000004", i_ready, i_rdata); end
        i_req = 1'b0; d_req = 1'b0;
      end
      m_ready = 1'b0;
    end
    tick(); tick();
    checks++; if (m_valid !== 1'b0 || dut.fair_q !== 3'd0) begin errors++; $display("FAIL fair_idle got v=%0b f=%0d exp 0 0", m_valid, dut.fair_q); end
  endtask

  task automatic test_late_ready();
    i_req = 1'b1; i_addr = 32'h0000_0500; m_ready = 1'b0;
    tick();
    for (int c = 0; c < 15; c++) tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL late_valid got %0b exp 1", m_valid); end
    m_ready = 1'b1; m_rdata = 32'h5555_AAAA;
    tick();
    checks++; if (i_ready !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL late_ready got r=%0b e=%0b exp 1 0", i_ready, bus_err); end
    checks++; if (i_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL late_rdata got %h exp 5555aaaa", i_rdata); end
    i_req = 1'b0; m_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    i_req = 1'b1; i_addr = 32'h0000_0600; m_ready = 1'b0;
    tick();
    while (m_valid === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL to_valid_cycles got %0d exp 16", cnt); end
    checks++; if (i_ready !== 1'b1 || bus_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse got r=%0b e=%0b exp 1 1", i_ready, bus_err); end
    checks++; if (i_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL to_rdata_kept got %h exp 5555aaaa", i_rdata); end
    i_req = 1'b0; m_ready = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick();
    checks++; if (i_ready !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse_len got r=%0b e=%0b exp 0 0", i_ready, bus_err); end
    tick();
    checks++; if (m_valid !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL to_stray_ready got v=%0b i=%0b d=%0b exp 0 0 0", m_valid, i_ready, d_ready); end
    checks++; if (i_rdata !== 32'h5555_AAAA || dut.state_q !== IDLE) begin errors++; $display("FAIL to_stray_state got %h st=%0d exp 5555aaaa IDLE", i_rdata, dut.state_q); end
    m_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700;
    tick(); tick(); tick();
    checks++; if (m_valid !== 1'b1 || dut.state_q !== BUSY_D) begin errors++; $display("FAIL rb_busy got v=%0b st=%0d exp 1 BUSY_D", m_valid, dut.state_q); end
    reset = 1'b1; d_req = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL rb_abort got v=%0b d=%0b exp 0 0", m_valid, d_ready); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rb_state got %0d exp IDLE", dut.state_q); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL rb_rdata_clr got %h exp 0", i_rdata); end
    reset = 1'b0;
    tick();
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rb_no_ready got %0b exp 0", d_ready); end
    i_req = 1'b1; i_addr = 32'h0000_0800;
    tick();
    checks++; if (m_valid !== 1'b1 || m_addr !== 32'h0000_0800) begin errors++; $display("FAIL rb_new_grant got v=%0b a=%h exp 1 00000800", m_valid, m_addr); end
    m_ready = 1'b1; m_rdata = 32'h0000_1234;
    tick();
    checks++; if (i_ready !== 1'b1 || i_rdata !== 32'h0000_1234) begin errors++; $display("FAIL rb_new_done got r=%0b d=%h exp 1 00001234", i_ready, i_rdata); end
    i_req = 1'b0; m_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_priority();
    test_fairness();
    test_late_ready();
    test_timeout();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles m_valid waits for m_ready.
REQ-004 Parameter FAIR_MAX, default 4, consecutive data grants allowed while an instruction request is pending.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 i_req  in  1  fetch-stage read request; held until i_ready.
REQ-008 i_addr  in  AW  fetch address.
REQ-009 i_rdata  out  DW  fetched word.
REQ-010 i_ready  out  1  one-cycle completion pulse to fetch port.
REQ-011 d_req  in  1  memory-stage request; held until d_ready.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  AW  data address.
REQ-014 d_wdata  in  DW  store data.
REQ-015 d_rdata  out  DW  load data.
REQ-016 d_ready  out  1  one-cycle completion pulse to data port.
REQ-017 m_valid  out  1  memory transaction valid.
REQ-018 m_we  out  1  memory write enable.
REQ-019 m_addr  out  AW  memory address.
REQ-020 m_wdata  out  DW  memory write data.
REQ-021 m_rdata  in  DW  memory read data, valid with m_ready.
REQ-022 m_ready  in  1  memory completion, may arrive 0..TIMEOUT-1 cycles after m_valid first rises.
REQ-023 bus_err  out  1  pulses with i_ready/d_ready when the transaction timed out.

Function
REQ-024 FSM states: IDLE, BUSY_I, BUSY_D, DONE.
REQ-025 IDLE: d_req wins over i_req, except when fair_cnt == FAIR_MAX and i_req is high, in which case the instruction port wins.
REQ-026 On grant, the arbiter registers the address, m_we (0 for instruction), and m_wdata, and enters BUSY_x; m_valid is high from the next cycle.
REQ-027 m_valid, m_we, m_addr and m_wdata are driven from registers and stay stable throughout BUSY_x.
REQ-028 In BUSY_x with m_ready high, the arbiter captures m_rdata into i_rdata (BUSY_I) or d_rdata (BUSY_D, loads only), drops m_valid and enters DONE.
REQ-029 DONE lasts exactly one cycle, asserts the matching ready pulse, grants nothing, then returns to IDLE.
REQ-030 Minimum latency: request sampled in cycle N, m_valid in N+1, ready pulse in N+2 when m_ready arrives in N+1; the next grant is sampled in N+3.
REQ-031 i_rdata and d_rdata hold their values until that port's next successful read; a store leaves d_rdata unchanged.
REQ-032 fair_cnt increments (saturating at FAIR_MAX) on each data grant made while i_req is high, and clears on any instruction grant.
REQ-033 The timeout counter clears on entry to BUSY_x and increments each BUSY_x cycle without m_ready.
REQ-034 When the timeout count reaches TIMEOUT, the arbiter drops m_valid, enters DONE with bus_err = 1, and leaves the rdata outputs unchanged.
REQ-035 m_ready in IDLE or DONE is ignored, which covers late responses after a timeout.
REQ-036 m_ready and the timeout in the same cycle: m_ready wins, and bus_err stays 0.

Reset
REQ-037 Reset forces state IDLE; m_valid, m_we, i_ready, d_ready, bus_err = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; fair_cnt and the timeout count = 0.
REQ-038 Reset during BUSY_x aborts the transaction with no ready pulse, and m_valid is 0 in the cycle after the reset edge.

Structure
REQ-039 Package mem_arb_pkg holds the state enum and the default AW, DW, TIMEOUT and FAIR_MAX constants.
REQ-040 Sub-module mem_arb_timer implements the clearable, saturating timeout counter with an expired output.

Verification
REQ-041 Instruction read only: i_req, i_addr=0x100, m_ready one cycle after m_valid with m_rdata=0x00500093 -> m_addr=0x100, m_we=0, i_ready pulse, i_rdata=0x00500093.
REQ-042 Simultaneous i_req and d_req (store 0xDEADBEEF to 0x2000) -> data granted first with m_we=1, m_wdata=0xDEADBEEF; instruction granted after d_ready.
REQ-043 d_req held continuously while i_req is pending -> exactly 4 data grants, then 1 instruction grant, then fair_cnt = 0.
REQ-044 m_ready never asserted, TIMEOUT=16 -> m_valid high exactly 16 cycles, then ready pulse with bus_err=1; a later stray m_ready is ignored.
REQ-045 Reset asserted in the 3rd cycle of BUSY_D -> no d_ready; m_valid=0 and state IDLE the next cycle; a new i_req completes normally.
